fetch_run_controller: RTL

- Debug-side sequencer for the instruction fetch stage.
- Accepts run, step, stop and clear commands over a valid/ready handshake and drives the fetch stage's PC-freeze input (stopPC_debug).
- Detects the halt instruction at the fetch output and drains the pipeline before reporting halted.
- Sits between the debug/UART command unit and the fetch stage.

---
 rtl/fetch_run_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_run_controller.sv
// Debug-side run/step/stop sequencer that drives the fetch stage's PC-freeze input.
// Define FETCH_CYCLE_COUNT_EN to build the running-cycle counter behind out_cycle_count.
module fetch_run_controller #(
  parameter int unsigned CNT_W        = 16,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [31:0]      in_instruction,
  input  logic [31:0]      in_pc,
  output logic             out_stop_pc,
  output logic             out_busy,
  output logic             out_halted,
  output logic             out_done,
  output logic             out_cmd_err,
  output logic [31:0]      out_halt_pc,
  output logic [31:0]      out_cycle_count
);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               stop_pc_q, stop_pc_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic               done_q, done_d;
  logic               cmd_err_q, cmd_err_d;
  logic [31:0]        halt_pc_q, halt_pc_d;
  logic               cmd_fire;
  logic               halt_seen;
  logic               halt_go;
  logic               clear_cnt;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_HALTED);
  assign cmd_fire  = cmd_valid && cmd_ready;
  // Only trust the instruction while the PC is actually advancing.
  assign halt_seen = !stop_pc_q && (in_instruction == HALT_INSTR);

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    halt_pc_d   = halt_pc_q;
    done_d      = 1'b0;
    cmd_err_d   = 1'b0;
    halt_go     = 1'b0;
    clear_cnt   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_RUN:   state_d = S_RUN;
            OP_STEP: begin
              state_d    = S_STEP;
              step_cnt_d = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
            end
            OP_CLEAR: clear_cnt = 1'b1;
            default:  ;
          endcase
        end
      end
      S_RUN: begin
        if (halt_seen) begin
          halt_go = 1'b1;
        end else if (cmd_fire) begin
          case (cmd_op)
            OP_STOP: state_d = S_IDLE;
            OP_CLEAR: begin
              cmd_err_d = 1'b1;
              clear_cnt = 1'b1;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      S_STEP: begin
        if (halt_seen) begin
          halt_go = 1'b1;
        end else if (step_cnt_q <= CNT_W'(1)) begin
          state_d    = S_IDLE;
          step_cnt_d = '0;
          done_d     = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q <= DRAIN_W'(1)) begin
          state_d     = S_HALTED;
          drain_cnt_d = '0;
          halted_d    = 1'b1;
          done_d      = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      S_HALTED: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_CLEAR: begin
              state_d   = S_IDLE;
              halted_d  = 1'b0;
              halt_pc_d = '0;
              clear_cnt = 1'b1;
            end
            OP_RUN, OP_STEP: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Halt wins over any command or step expiry seen in the same cycle.
    if (halt_go) begin
      halt_pc_d  = in_pc;
      step_cnt_d = '0;
      if (DRAIN_CYCLES == 0) begin
        state_d  = S_HALTED;
        halted_d = 1'b1;
        done_d   = 1'b1;
      end else begin
        state_d     = S_DRAIN;
        drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
      end
    end

    stop_pc_d = !((state_d == S_RUN) || (state_d == S_STEP));
    busy_d    = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      step_cnt_q  <= '0;
      drain_cnt_q <= '0;
      stop_pc_q   <= 1'b1;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      halt_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stop_pc_q   <= stop_pc_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      done_q      <= done_d;
      cmd_err_q   <= cmd_err_d;
      halt_pc_q   <= halt_pc_d;
    end
  end

  assign out_stop_pc = stop_pc_q;
  assign out_busy    = busy_q;
  assign out_halted  = halted_q;
  assign out_done    = done_q;
  assign out_cmd_err = cmd_err_q;
  assign out_halt_pc = halt_pc_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (clear_cnt) begin
      cycle_cnt_d = '0;
    end else if (!stop_pc_q && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign out_cycle_count = cycle_cnt_q;
`else
  logic cycle_cnt_unused;
  assign cycle_cnt_unused = clear_cnt;
  assign out_cycle_count  = '0;
`endif

endmodule
